alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Upstream feeder for the 32-bit ALU. Accepts instruction words over a valid/ready handshake, decodes them, reads two source operands from a 16 x 32 register file, and presents registered `a`, `b`, `op` to the ALU with its own valid/ready handshake. A write-back port returns ALU results into the register file. A per-register busy scoreboard stalls RAW and WAW hazards.

## Interface
Parameters:
- NREGS, 16, register count; address width is log2(NREGS) = 4.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage accepts the word this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  operands valid for the ALU.
- out_ready  in  1  ALU side consumes this cycle.
- out_a  out  32  ALU operand a (rs1 value).
- out_b  out  32  ALU operand b (rs2 value or immediate).
- out_op  out  3  ALU op code.
- out_rd  out  4  destination tag travelling with the operation.
- wb_en  in  1  write-back strobe.
- wb_addr  in  4  write-back register.
- wb_data  in  32  write-back value (ALU result).
- illegal  out  1  one-cycle pulse when an undefined op is dropped.

## Operation
- Instruction fields:
  - [31:29] op
  - [28:25] rd
  - [24:21] rs1
  - [20:17] rs2
  - [16] imm_sel
  - [15:0] imm, zero-extended to 32.
- Op encodings: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SHR, 101 SHL. 110 and 111 are illegal.
- Register r0 reads as 0. Writes to r0 are ignored, and r0 is never marked busy.
- The `b` source is rs2 when imm_sel=0, else imm. Busy checks apply to rs2 only when imm_sel=0.
- Hazard check: stall if rs1 is busy, or if rs2 is used and busy, or if rd is busy.
- Write-back on the same cycle clears the hazard. A register whose busy bit is being cleared by a write-back this cycle counts as not busy.
- Write-back bypass: if wb_en, wb_addr == source, and the source is nonzero, the operand takes wb_data.
- in_ready = (!out_valid || out_ready) && !hazard. An illegal op ignores the hazard term.
- Accept (in_valid && in_ready), legal op:
  - Capture out_a, out_b, out_op, out_rd.
  - Set out_valid.
  - Set busy[rd] if rd != 0.
- Accept, illegal op: the word is dropped, illegal pulses the next cycle, out_* is unchanged, and busy is not set.
- Write-back clears busy[wb_addr] and writes the register file.
- Simultaneous set and clear of the same register: set wins. This can only happen when rd == wb_addr, because the WAW check otherwise stalls.
- While out_valid && !out_ready, all out_* signals hold stable.

## Timing
- Reset: all out_* are 0, out_valid = 0, illegal = 0, every busy bit is 0, every register is 0, and in_ready = 1.
- Latency: an accept in cycle N gives out_valid=1 with its operands in cycle N+1.
- Throughput: one instruction per cycle when out_ready=1 and there are no hazards.
- A register-file write lands at the clock edge and is visible to reads in the next cycle. Same-cycle visibility is provided only by the bypass.
- out_valid falls one cycle after an out_ready handshake if there is no new accept in that cycle.
- An asynchronous reset asserted mid-operation clears everything immediately, including any pending busy bits. Write-backs of in-flight results after reset are ignored until rst_n deasserts.

## Structure
- Shared package alu_pkg holds:
  - Op encodings (OP_AND..OP_SHL).
  - Instruction field bit positions.
  - NREGS and XLEN defaults.
  - Function is_legal_op.
- Sub-module alu_regfile:
  - NREGS x XLEN storage.
  - Two combinational read ports and one write port.
  - r0 forced to zero.
  - Write-back bypass on both read ports.
- The scoreboard, handshake, and output register stay in the top level.

## Test plan
- Reset then idle -> in_ready=1, out_valid=0, all outputs 0. A read of any register after a write-back of 0x0000_0000 returns 0.
- Preload r1=0x0000_00F0 via wb, then issue ADD rd=2 rs1=1 imm_sel=1 imm=0x0010 -> next cycle out_a=0xF0, out_b=0x10, out_op=010, out_rd=2, busy[2]=1.
- Issue SUB rd=3 rs1=2 rs2=0 immediately after the previous ADD, with no write-back -> in_ready=0. Drive wb_en wb_addr=2 wb_data=0x100 -> accepted that cycle with out_a=0x100 via bypass.
- Hold out_ready=0 with out_valid=1 for 3 cycles, then present a new valid instruction -> in_ready=0 and out_* stable. Release out_ready -> new operands appear the following cycle.
- Instruction with op=110 -> accepted, illegal=1 for one cycle, out_valid unchanged, no busy bit set.
- Assert rst_n=0 while busy[5]=1 and out_valid=1 -> outputs clear immediately, busy[5]=0, and in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, instruction field layout and sizing defaults for the ALU issue stage
package alu_pkg;

   localparam int DEF_NREGS = 16;
   localparam int DEF_XLEN  = 32;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_SHR = 3'b100,
      OP_SHL = 3'b101
   } alu_op_t;

   localparam int OP_MSB      = 31;
   localparam int OP_LSB      = 29;
   localparam int RD_MSB      = 28;
   localparam int RD_LSB      = 25;
   localparam int RS1_MSB     = 24;
   localparam int RS1_LSB     = 21;
   localparam int RS2_MSB     = 20;
   localparam int RS2_LSB     = 17;
   localparam int IMM_SEL_BIT = 16;
   localparam int IMM_MSB     = 15;
   localparam int IMM_LSB     = 0;

   function automatic logic is_legal_op(input logic [2:0] op);
      return op <= OP_SHL;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - instruction, ALU-operand and write-back signals of the issue stage
interface alu_issue_stage_if
   import alu_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int XLEN  = DEF_XLEN
);
   localparam int AW = $clog2(NREGS);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_a;
   logic [XLEN-1:0] out_b;
   logic [2:0]      out_op;
   logic [AW-1:0]   out_rd;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;
   logic            illegal;

   modport master (
      output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
      input  in_ready, out_valid, out_a, out_b, out_op, out_rd, illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
      output in_ready, out_valid, out_a, out_b, out_op, out_rd, illegal
   );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with two bypassed combinational read ports, one write port, r0 hardwired to zero
module alu_regfile #(
   parameter int NREGS = 16,
   parameter int XLEN  = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rd_addr_a,
   output logic [XLEN-1:0] rd_data_a,
   input  logic [AW-1:0]   rd_addr_b,
   output logic [XLEN-1:0] rd_data_b,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (wr_en && wr_addr != '0) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Bypass gives the issuing instruction a result that is only being written this cycle
   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
      if (addr == '0)
         return '0;
      else if (wr_en && wr_addr == addr)
         return wr_data;
      else
         return mem[addr];
   endfunction

   always_comb begin
      rd_data_a = read_port(rd_addr_a);
      rd_data_b = read_port(rd_addr_b);
   end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decodes instruction words, checks the busy scoreboard and registers ALU operands
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int XLEN  = DEF_XLEN
) (
   input logic               clk,
   input logic               rst_n,
   alu_issue_stage_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic [2:0]      op;
   logic [AW-1:0]   rd;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic            imm_sel;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   assign op      = bus.in_instr[OP_MSB:OP_LSB];
   assign rd      = bus.in_instr[RD_MSB:RD_LSB];
   assign rs1     = bus.in_instr[RS1_MSB:RS1_LSB];
   assign rs2     = bus.in_instr[RS2_MSB:RS2_LSB];
   assign imm_sel = bus.in_instr[IMM_SEL_BIT];
   assign imm_ext = {{(XLEN-16){1'b0}}, bus.in_instr[IMM_MSB:IMM_LSB]};

   alu_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (rs1),
      .rd_data_a (rs1_val),
      .rd_addr_b (rs2),
      .rd_data_b (rs2_val),
      .wr_en     (bus.wb_en),
      .wr_addr   (bus.wb_addr),
      .wr_data   (bus.wb_data)
   );

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] wb_clr;
   logic [NREGS-1:0] busy_eff;
   logic [NREGS-1:0] busy_next;
   logic             legal;
   logic             hazard;
   logic             accept;

   // A register being written back this cycle no longer blocks issue
   always_comb begin
      wb_clr = '0;
      if (bus.wb_en && bus.wb_addr != '0) wb_clr[bus.wb_addr] = 1'b1;
   end

   assign busy_eff     = busy & ~wb_clr;
   assign legal        = is_legal_op(op);
   assign hazard       = busy_eff[rs1] | (!imm_sel && busy_eff[rs2]) | busy_eff[rd];
   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && (!legal || !hazard);
   assign accept       = bus.in_valid && bus.in_ready;

   // Set is applied after clear so a same-register issue and write-back leaves it busy
   always_comb begin
      busy_next = busy & ~wb_clr;
      if (accept && legal && rd != '0) busy_next[rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_a     <= '0;
         bus.out_b     <= '0;
         bus.out_op    <= '0;
         bus.out_rd    <= '0;
         bus.illegal   <= 1'b0;
         busy          <= '0;
      end else begin
         bus.illegal <= accept && !legal;
         busy        <= busy_next;
         if (accept && legal) begin
            bus.out_valid <= 1'b1;
            bus.out_a     <= rs1_val;
            bus.out_b     <= imm_sel ? imm_ext : rs2_val;
            bus.out_op    <= op;
            bus.out_rd    <= rd;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_issue_stage_if bus ();

   alu_issue_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic sel, input logic [15:0] imm);
      return {op, rd, rs1, rs2, sel, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.out_ready = 1'b1;
      bus.wb_en     = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      tick();
      tick();

      chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_a",     bus.out_a, 32'd0);
      chk("rst_out_b",     bus.out_b, 32'd0);
      chk("rst_out_op",    32'(bus.out_op), 32'd0);
      chk("rst_out_rd",    32'(bus.out_rd), 32'd0);
      chk("rst_illegal",   32'(bus.illegal), 32'd0);
      chk("rst_busy",      32'(dut.busy), 32'd0);

      rst_n = 1'b1;
      tick();

      bus.wb_en = 1'b1; bus.wb_addr = 4'd1; bus.wb_data = 32'h0000_00F0;
      tick();
      bus.wb_addr = 4'd4; bus.wb_data = 32'h0000_0000;
      tick();

      bus.wb_en = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_instr = mk(OP_AND, 4'd0, 4'd4, 4'd4, 1'b0, 16'h0000);
      #1 chk("and_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("and_out_valid", 32'(bus.out_valid), 32'd1);
      chk("and_out_a",     bus.out_a, 32'd0);
      chk("and_out_b",     bus.out_b, 32'd0);
      chk("and_r0_busy",   32'(dut.busy), 32'd0);

      bus.in_instr = mk(OP_ADD, 4'd2, 4'd1, 4'd0, 1'b1, 16'h0010);
      #1 chk("add_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("add_out_valid", 32'(bus.out_valid), 32'd1);
      chk("add_out_a",     bus.out_a, 32'h0000_00F0);
      chk("add_out_b",     bus.out_b, 32'h0000_0010);
      chk("add_out_op",    32'(bus.out_op), 32'd2);
      chk("add_out_rd",    32'(bus.out_rd), 32'd2);
      chk("add_busy",      32'(dut.busy), 32'h0000_0004);

      bus.in_instr = mk(OP_SUB, 4'd3, 4'd2, 4'd0, 1'b0, 16'h0000);
      #1 chk("sub_raw_stall", 32'(bus.in_ready), 32'd0);
      bus.wb_en = 1'b1; bus.wb_addr = 4'd2; bus.wb_data = 32'h0000_0100;
      #1 chk("sub_wb_release", 32'(bus.in_ready), 32'd1);
      tick();
      chk("sub_out_a_bypass", bus.out_a, 32'h0000_0100);
      chk("sub_out_b",        bus.out_b, 32'd0);
      chk("sub_out_op",       32'(bus.out_op), 32'd3);
      chk("sub_out_rd",       32'(bus.out_rd), 32'd3);
      chk("sub_busy",         32'(dut.busy), 32'h0000_0008);

      bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_out_a",     bus.out_a, 32'h0000_0100);
      end
      bus.in_valid = 1'b1;
      bus.in_instr = mk(OP_OR, 4'd5, 4'd1, 4'd4, 1'b0, 16'h0000);
      #1 chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("hold2_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold2_out_a",     bus.out_a, 32'h0000_0100);
      chk("hold2_out_op",    32'(bus.out_op), 32'd3);
      chk("hold2_out_rd",    32'(bus.out_rd), 32'd3);
      bus.out_ready = 1'b1;
      #1 chk("release_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("or_out_a",  bus.out_a, 32'h0000_00F0);
      chk("or_out_b",  bus.out_b, 32'd0);
      chk("or_out_op", 32'(bus.out_op), 32'd1);
      chk("or_out_rd", 32'(bus.out_rd), 32'd5);
      chk("or_busy",   32'(dut.busy), 32'h0000_0028);

      bus.in_valid = 1'b0;
      tick();
      chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
      chk("drain_out_a",     bus.out_a, 32'h0000_00F0);

      bus.in_valid = 1'b1;
      bus.in_instr = mk(3'b110, 4'd6, 4'd3, 4'd5, 1'b0, 16'h0000);
      #1 chk("ill_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("ill_pulse",     32'(bus.illegal), 32'd1);
      chk("ill_out_valid", 32'(bus.out_valid), 32'd0);
      chk("ill_out_a",     bus.out_a, 32'h0000_00F0);
      chk("ill_out_op",    32'(bus.out_op), 32'd1);
      chk("ill_busy",      32'(dut.busy), 32'h0000_0028);
      bus.in_valid = 1'b0;
      tick();
      chk("ill_pulse_end", 32'(bus.illegal), 32'd0);

      bus.in_valid = 1'b1;
      bus.in_instr = mk(OP_ADD, 4'd5, 4'd5, 4'd0, 1'b1, 16'h0001);
      bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'h0000_0007;
      #1 chk("waw_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("waw_out_valid", 32'(bus.out_valid), 32'd1);
      chk("waw_out_a",     bus.out_a, 32'h0000_0007);
      chk("waw_out_b",     bus.out_b, 32'h0000_0001);
      chk("waw_set_wins",  32'(dut.busy), 32'h0000_0028);

      bus.in_valid = 1'b0; bus.wb_en = 1'b0; bus.out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out_a",     bus.out_a, 32'd0);
      chk("arst_out_b",     bus.out_b, 32'd0);
      chk("arst_out_rd",    32'(bus.out_rd), 32'd0);
      chk("arst_busy",      32'(dut.busy), 32'd0);
      bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'h0000_0055;
      tick();
      tick();
      bus.wb_en = 1'b0;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = mk(OP_ADD, 4'd3, 4'd3, 4'd5, 1'b0, 16'h0000);
      #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("post_rst_out_a",  bus.out_a, 32'd0);
      chk("post_rst_out_b",  bus.out_b, 32'd0);
      chk("post_rst_out_rd", 32'(bus.out_rd), 32'd3);
      bus.in_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
